// File: rtl/arb_reg_sca.sv
// Round-robin arbiter for two write masters and one read master in front of a
// scalar register file, with a register-file clear sequence.
module arb_reg_sca #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wreq0,
   input  logic [AW-1:0] wdir0,
   input  logic [DW-1:0] wdat0,
   input  logic          wreq1,
   input  logic [AW-1:0] wdir1,
   input  logic [DW-1:0] wdat1,
   input  logic          rreq,
   input  logic [AW-1:0] rdir,
   input  logic          clr,
   output logic          gnt_w0,
   output logic          gnt_w1,
   output logic          gnt_r,
   output logic          reg_wr,
   output logic [AW-1:0] dir_wrs,
   output logic [DW-1:0] data_wr,
   output logic          reg_rd,
   output logic [AW-1:0] reg_sca1,
   output logic          busy
);

   localparam int unsigned NREG = 2**AW;
   localparam logic [1:0] M_W0 = 2'd0;
   localparam logic [1:0] M_W1 = 2'd1;
   localparam logic [1:0] M_R  = 2'd2;

   typedef enum logic {ARB, CLEAR} state_t;

   state_t        state, state_n;
   logic [AW-1:0] cnt, cnt_n;
   logic [1:0]    last, last_n;
   logic          gnt_w0_n, gnt_w1_n, gnt_r_n, reg_wr_n, reg_rd_n, busy_n;
   logic [AW-1:0] dir_wrs_n, reg_sca1_n;
   logic [DW-1:0] data_wr_n;
   logic [2:0]    elig;
   logic          found;
   logic [1:0]    sel, cand;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB;
         cnt      <= '0;
         last     <= M_R;
         gnt_w0   <= 1'b0;
         gnt_w1   <= 1'b0;
         gnt_r    <= 1'b0;
         reg_wr   <= 1'b0;
         reg_rd   <= 1'b0;
         busy     <= 1'b0;
         dir_wrs  <= '0;
         data_wr  <= '0;
         reg_sca1 <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         last     <= last_n;
         gnt_w0   <= gnt_w0_n;
         gnt_w1   <= gnt_w1_n;
         gnt_r    <= gnt_r_n;
         reg_wr   <= reg_wr_n;
         reg_rd   <= reg_rd_n;
         busy     <= busy_n;
         dir_wrs  <= dir_wrs_n;
         data_wr  <= data_wr_n;
         reg_sca1 <= reg_sca1_n;
      end
   end

   // Next-state, arbitration and next-output logic
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      last_n     = last;
      gnt_w0_n   = 1'b0;
      gnt_w1_n   = 1'b0;
      gnt_r_n    = 1'b0;
      reg_wr_n   = 1'b0;
      reg_rd_n   = 1'b0;
      busy_n     = 1'b0;
      dir_wrs_n  = dir_wrs;
      data_wr_n  = data_wr;
      reg_sca1_n = reg_sca1;

      // A master currently showing its grant is not eligible this edge
      elig  = {rreq & ~gnt_r, wreq1 & ~gnt_w1, wreq0 & ~gnt_w0};
      found = 1'b0;
      sel   = last;
      cand  = last;
      for (int k = 0; k < 3; k++) begin
         cand = (cand == M_R) ? M_W0 : cand + 2'd1;
         if (!found && elig[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end

      case (state)
         ARB: begin
            if (clr) begin
               state_n   = CLEAR;
               busy_n    = 1'b1;
               reg_wr_n  = 1'b1;
               dir_wrs_n = '0;
               data_wr_n = '0;
               cnt_n     = AW'(1);
            end else if (found) begin
               last_n = sel;
               case (sel)
                  M_W0: begin
                     gnt_w0_n  = 1'b1;
                     reg_wr_n  = 1'b1;
                     dir_wrs_n = wdir0;
                     data_wr_n = wdat0;
                  end
                  M_W1: begin
                     gnt_w1_n  = 1'b1;
                     reg_wr_n  = 1'b1;
                     dir_wrs_n = wdir1;
                     data_wr_n = wdat1;
                  end
                  default: begin
                     gnt_r_n    = 1'b1;
                     reg_rd_n   = 1'b1;
                     reg_sca1_n = rdir;
                  end
               endcase
            end
         end
         CLEAR: begin
            // Index 0 was written on entry; walk the rest, wrapping cnt to 0
            busy_n    = 1'b1;
            reg_wr_n  = 1'b1;
            dir_wrs_n = cnt;
            data_wr_n = '0;
            cnt_n     = cnt + AW'(1);
            if (cnt == AW'(NREG - 1)) state_n = ARB;
         end
      endcase
   end

endmodule

// File: tb/tb_arb_reg_sca.sv
// Self-checking bench for arb_reg_sca: directed scenarios plus randomized
// traffic compared every cycle against a behavioural round-robin model.
module tb_arb_reg_sca;

   localparam int DW   = 8;
   localparam int AW   = 3;
   localparam int NREG = 8;

   logic          clk = 1'b0;
   logic          rst, wreq0, wreq1, rreq, clr;
   logic [AW-1:0] wdir0, wdir1, rdir;
   logic [DW-1:0] wdat0, wdat1;
   logic          gnt_w0, gnt_w1, gnt_r, reg_wr, reg_rd, busy;
   logic [AW-1:0] dir_wrs, reg_sca1;
   logic [DW-1:0] data_wr;

   arb_reg_sca #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .wreq0(wreq0), .wdir0(wdir0), .wdat0(wdat0),
      .wreq1(wreq1), .wdir1(wdir1), .wdat1(wdat1),
      .rreq(rreq), .rdir(rdir), .clr(clr),
      .gnt_w0(gnt_w0), .gnt_w1(gnt_w1), .gnt_r(gnt_r),
      .reg_wr(reg_wr), .dir_wrs(dir_wrs), .data_wr(data_wr),
      .reg_rd(reg_rd), .reg_sca1(reg_sca1), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: last-granted master index, previous-cycle grant, clear progress
   int            m_last = 2;
   int            m_prev = -1;
   int            m_left = 0;
   int            m_idx  = 0;
   logic          e_g0 = 0, e_g1 = 0, e_gr = 0, e_wr = 0, e_rd = 0, e_busy = 0;
   logic [AW-1:0] e_dir = '0, e_sca = '0;
   logic [DW-1:0] e_dat = '0;

   task automatic model_edge();
      bit rq[3];
      int g;
      int m;
      rq[0] = wreq0;
      rq[1] = wreq1;
      rq[2] = rreq;
      e_g0 = 0; e_g1 = 0; e_gr = 0; e_wr = 0; e_rd = 0;
      if (rst) begin
         e_dir = '0; e_dat = '0; e_sca = '0; e_busy = 0;
         m_last = 2; m_prev = -1; m_left = 0; m_idx = 0;
      end else if (m_left > 0) begin
         e_wr = 1; e_dir = AW'(m_idx); e_dat = '0; e_busy = 1;
         m_idx++; m_left--; m_prev = -1;
      end else if (clr) begin
         e_wr = 1; e_dir = '0; e_dat = '0; e_busy = 1;
         m_idx = 1; m_left = NREG - 1; m_prev = -1;
      end else begin
         e_busy = 0;
         g = -1;
         for (int k = 1; k <= 3; k++) begin
            m = (m_last + k) % 3;
            if (g < 0 && rq[m] && m != m_prev) g = m;
         end
         m_prev = g;
         if (g >= 0) m_last = g;
         case (g)
            0: begin e_g0 = 1; e_wr = 1; e_dir = wdir0; e_dat = wdat0; end
            1: begin e_g1 = 1; e_wr = 1; e_dir = wdir1; e_dat = wdat1; end
            2: begin e_gr = 1; e_rd = 1; e_sca = rdir; end
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("cycle",
            32'({gnt_w0, gnt_w1, gnt_r, reg_wr, reg_rd, busy, dir_wrs, reg_sca1, data_wr}),
            32'({e_g0, e_g1, e_gr, e_wr, e_rd, e_busy, e_dir, e_sca, e_dat}));
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask

   initial begin
      rst = 1; wreq0 = 0; wreq1 = 0; rreq = 0; clr = 0;
      wdir0 = '0; wdir1 = '0; rdir = '0; wdat0 = '0; wdat1 = '0;
      #2;
      tick();
      check("rst_out", 32'({gnt_w0, gnt_w1, gnt_r, reg_wr, reg_rd, busy, dir_wrs, reg_sca1, data_wr}), 32'd0);
      rst = 0;

      // Single uncontended write
      wreq0 = 1; wdir0 = 3'd2; wdat0 = 8'h5A;
      tick();
      check("w0_grant", 32'({gnt_w0, reg_wr, dir_wrs, data_wr}), 32'({1'b1, 1'b1, 3'd2, 8'h5A}));
      wreq0 = 0;
      tick();
      check("w0_done", 32'(reg_wr), 32'd0);

      // All three requesting: strict rotation from reset
      wreq0 = 1; wreq1 = 1; rreq = 1;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rr_order", 32'({gnt_w0, gnt_w1, gnt_r}), 32'(3'b100 >> (i % 3)));
      end

      // Lone held request alternates
      wreq0 = 0; rreq = 0; wreq1 = 1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("w1_alt", 32'(gnt_w1), 32'(i % 2 == 0));
      end
      wreq1 = 0;

      // Clear beats a pending write, which is granted right after
      do_reset();
      wreq0 = 1; wdir0 = 3'd5; clr = 1;
      for (int i = 0; i < NREG; i++) begin
         tick();
         clr = 0;
         check("clr_seq", 32'({busy, reg_wr, dir_wrs, data_wr, gnt_w0, gnt_w1, gnt_r}),
               32'({1'b1, 1'b1, 3'(i), 8'h00, 3'b000}));
      end
      tick();
      check("clr_exit", 32'({busy, gnt_w0}), 32'b01);
      wreq0 = 0;

      // Reset aborts a clear in its 4th cycle
      do_reset();
      clr = 1;
      tick();
      clr = 0;
      tick(); tick(); tick();
      rst = 1;
      tick();
      check("clr_abort", 32'({busy, reg_wr, dir_wrs}), 32'd0);
      rst = 0; wreq0 = 1; wreq1 = 1;
      tick();
      check("post_abort", 32'({gnt_w0, gnt_w1}), 32'b10);
      wreq0 = 0; wreq1 = 0;

      // Read request concurrent with clear is served afterwards
      do_reset();
      rreq = 1; rdir = 3'd7; clr = 1;
      for (int i = 0; i < NREG; i++) begin
         tick();
         clr = 0;
      end
      tick();
      check("read_after_clr", 32'({gnt_r, reg_rd, reg_sca1}), 32'({1'b1, 1'b1, 3'd7}));
      rreq = 0;

      // Randomized traffic; address/data only change while idle or just granted
      do_reset();
      for (int n = 0; n < 800; n++) begin
         if (!wreq0 || e_g0) begin
            wreq0 = 1'($urandom_range(0, 1)); wdir0 = AW'($urandom); wdat0 = DW'($urandom);
         end
         if (!wreq1 || e_g1) begin
            wreq1 = 1'($urandom_range(0, 1)); wdir1 = AW'($urandom); wdat1 = DW'($urandom);
         end
         if (!rreq || e_gr) begin
            rreq = 1'($urandom_range(0, 1)); rdir = AW'($urandom);
         end
         clr = ($urandom_range(0, 29) == 0);
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
